// File: rtl/filter_mode_sequencer.sv
// Filter-mode sequencer for the VGA filtering path.
// Synchronises and debounces the filter-select switches, commits a new
// filter selection only on a frame start, and blanks the output for a
// programmable number of frames after every commit.
module filter_mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter int unsigned BLANK_FRAMES     = 2,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [3:0]  RESET_MODE       = 4'b0000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [3:0]  sw_in,
    input  logic        vsync_in,
    output logic [3:0]  mode_out,
    output logic        mode_change,
    output logic        blank_out,
    output logic        pending,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned BW = (BLANK_FRAMES != 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_FRAMES);
    localparam logic VS_ACTIVE = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        BLANK
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [3:0]      sw_m;
    logic [3:0]      sw_s;
    logic [3:0]      candidate;
    logic [3:0]      sw_db;
    logic [CW-1:0]   db_cnt;
    logic            vs_d;
    logic            frame_start;
    logic [BW-1:0]   blank_cnt;
    logic            commit;
    logic            blank_dec;
    logic            blank_end;

    // Two-flop switch synchroniser followed by the stability counter.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sw_m      <= RESET_MODE;
            sw_s      <= RESET_MODE;
            candidate <= RESET_MODE;
            sw_db     <= RESET_MODE;
            db_cnt    <= '0;
        end else begin
            sw_m <= sw_in;
            sw_s <= sw_m;
            if (sw_s != candidate) begin
                candidate <= sw_s;
                db_cnt    <= '0;
            end else if (db_cnt != CNT_MAX) begin
                db_cnt <= db_cnt + CW'(1);
            end
            if (db_cnt == CNT_MAX) begin
                sw_db <= candidate;
            end
        end
    end

    // A frame starts on the first cycle vsync is seen at its active level.
    assign frame_start = (vs_d != VS_ACTIVE) && (vsync_in == VS_ACTIVE);

    // vsync edge history and the free-running frame counter.
    always_ff @(posedge pclk) begin
        if (rst) begin
            // Starting at the active level prevents a false frame start
            // when vsync is already active as reset is released.
            vs_d      <= VS_ACTIVE;
            frame_cnt <= '0;
        end else begin
            vs_d <= vsync_in;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Next-state logic: commits happen only on frame starts, and only from
    // PENDING or at the end of a blanking window.
    always_comb begin
        state_n   = state;
        commit    = 1'b0;
        blank_dec = 1'b0;
        blank_end = 1'b0;
        case (state)
            IDLE: begin
                if (sw_db != mode_out) begin
                    state_n = PENDING;
                end
            end
            PENDING: begin
                if (sw_db == mode_out) begin
                    state_n = IDLE;
                end else if (frame_start) begin
                    commit  = 1'b1;
                    state_n = (BLANK_FRAMES != 0) ? BLANK : IDLE;
                end
            end
            BLANK: begin
                if (frame_start) begin
                    if (blank_cnt <= BW'(1)) begin
                        if (sw_db != mode_out) begin
                            commit = 1'b1;
                        end else begin
                            blank_end = 1'b1;
                            state_n   = IDLE;
                        end
                    end else begin
                        blank_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus the registered mode, pulse, blanking and pending outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            mode_out    <= RESET_MODE;
            mode_change <= 1'b0;
            blank_out   <= 1'b0;
            blank_cnt   <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_n;
            mode_change <= commit;
            pending     <= (sw_db != mode_out);
            if (commit) begin
                mode_out <= sw_db;
            end
            if (commit && (BLANK_FRAMES != 0)) begin
                blank_out <= 1'b1;
                blank_cnt <= BLANK_LOAD;
            end else if (blank_dec) begin
                blank_cnt <= blank_cnt - BW'(1);
            end else if (blank_end) begin
                blank_out <= 1'b0;
                blank_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Directed bench for filter_mode_sequencer: vsync is low for 2 of every
// 100 cycles; a vector table covers debounce/commit cases and hand-written
// sequences cover reset, blanking, re-commit and frame counter wrap.
module tb_filter_mode_sequencer;

    logic        pclk;
    logic        rst;
    logic [3:0]  sw_in;
    logic        vsync_in;
    logic [3:0]  mode_out;
    logic        mode_change;
    logic        blank_out;
    logic        pending;
    logic [15:0] frame_cnt;

    filter_mode_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .BLANK_FRAMES    (2),
        .VSYNC_ACTIVE_LOW(1'b1),
        .RESET_MODE      (4'h0)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .sw_in      (sw_in),
        .vsync_in   (vsync_in),
        .mode_out   (mode_out),
        .mode_change(mode_change),
        .blank_out  (blank_out),
        .pending    (pending),
        .frame_cnt  (frame_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        logic [3:0]  sw_a;
        int unsigned hold;
        logic [3:0]  sw_b;
        logic        exp_pend;
        logic [3:0]  exp_mode;
        int unsigned exp_ch;
    } vec_t;

    int          n_cmp;
    int          n_err;
    int unsigned phase;
    logic        mvs_d;
    logic [15:0] exp_fc;
    logic        last_fs;
    logic        mon_en;
    int unsigned mon_ch;
    logic        mon_pend;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive vsync.
    task automatic step();
        @(negedge pclk);
        last_fs = !rst && mvs_d && !vsync_in;
        mvs_d   = rst ? 1'b0 : vsync_in;
        if (last_fs) exp_fc = exp_fc + 16'd1;
        if (mon_en) begin
            if (mode_change) mon_ch++;
            if (pending) mon_pend = 1'b1;
        end
        phase    = (phase == 99) ? 0 : phase + 1;
        vsync_in = (phase < 2) ? 1'b0 : 1'b1;
    endtask

    task automatic wait_fs();
        int unsigned k;
        k = 0;
        do begin
            step();
            k++;
        end while (!last_fs && k < 300);
        if (!last_fs) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_start_timeout: got none, want one within 300 cycles");
        end
    endtask

    task automatic wait_phase(input int unsigned p);
        int unsigned k;
        k = 0;
        while (phase != p && k < 200) begin
            step();
            k++;
        end
    endtask

    vec_t vecs[7];

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        phase    = 97;
        mvs_d    = 1'b0;
        exp_fc   = 16'd0;
        last_fs  = 1'b0;
        mon_en   = 1'b0;
        mon_ch   = 0;
        mon_pend = 1'b0;
        rst      = 1'b1;
        sw_in    = 4'hF;
        vsync_in = 1'b1;

        // {sw_a, hold cycles, sw_b, pending seen, mode after frame, mode_change pulses}
        vecs[0] = '{4'h3, 3,  4'h9, 1'b0, 4'h9, 0};
        vecs[1] = '{4'h3, 4,  4'h9, 1'b1, 4'h9, 0};
        vecs[2] = '{4'h0, 40, 4'h0, 1'b1, 4'h0, 1};
        vecs[3] = '{4'h5, 30, 4'h7, 1'b1, 4'h7, 1};
        vecs[4] = '{4'h2, 2,  4'h7, 1'b0, 4'h7, 0};
        vecs[5] = '{4'h4, 1,  4'h7, 1'b0, 4'h7, 0};
        vecs[6] = '{4'h5, 40, 4'h5, 1'b1, 4'h5, 1};

        // Reset with vsync toggling and switches at F.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mode", 32'(mode_out), 0);
            chk("rst_change", 32'(mode_change), 0);
            chk("rst_blank", 32'(blank_out), 0);
            chk("rst_pending", 32'(pending), 0);
            chk("rst_fcnt", 32'(frame_cnt), 0);
        end
        rst = 1'b0;
        step();
        sw_in = 4'h0;
        chk("post_rst_mode", 32'(mode_out), 0);
        chk("post_rst_fcnt", 32'(frame_cnt), 0);
        wait_fs();
        wait_fs();
        chk("fcnt_two_frames", 32'(frame_cnt), 2);
        chk("idle_mode", 32'(mode_out), 0);
        chk("idle_pending", 32'(pending), 0);

        // Debounced commit of 5 and its blanking window.
        wait_phase(10);
        sw_in = 4'h5;
        begin
            int unsigned k;
            k = 0;
            do begin
                step();
                k++;
            end while (!pending && k < 20);
            n_cmp++;
            if (!(k >= 6 && k <= 8)) begin
                n_err++;
                $display("FAIL pend_latency: got %0d cycles, want 6..8", k);
            end
        end
        chk("pre_commit_mode", 32'(mode_out), 0);
        wait_fs();
        chk("commit5_mode", 32'(mode_out), 5);
        chk("commit5_change", 32'(mode_change), 1);
        chk("commit5_blank", 32'(blank_out), 1);
        step();
        chk("commit5_pulse_end", 32'(mode_change), 0);
        chk("commit5_pending_clr", 32'(pending), 0);
        wait_fs();
        chk("blank_frame1", 32'(blank_out), 1);
        chk("blank_frame1_change", 32'(mode_change), 0);
        wait_fs();
        chk("blank_frame2_off", 32'(blank_out), 0);
        chk("blank_frame2_mode", 32'(mode_out), 5);

        // Switch change during blanking re-commits at the end of the window.
        sw_in = 4'h0;
        repeat (4) wait_fs();
        chk("back_to0_mode", 32'(mode_out), 0);
        chk("back_to0_blank", 32'(blank_out), 0);
        sw_in = 4'h5;
        wait_fs();
        chk("b_commit5_mode", 32'(mode_out), 5);
        chk("b_commit5_change", 32'(mode_change), 1);
        wait_phase(10);
        sw_in = 4'h9;
        repeat (12) step();
        chk("b_pending9", 32'(pending), 1);
        chk("b_hold5", 32'(mode_out), 5);
        chk("b_blank_held", 32'(blank_out), 1);
        wait_fs();
        chk("b_f1_mode", 32'(mode_out), 5);
        chk("b_f1_change", 32'(mode_change), 0);
        chk("b_f1_blank", 32'(blank_out), 1);
        wait_fs();
        chk("b_f2_mode", 32'(mode_out), 9);
        chk("b_f2_change", 32'(mode_change), 1);
        chk("b_f2_blank", 32'(blank_out), 1);
        wait_fs();
        chk("b_f3_blank", 32'(blank_out), 1);
        wait_fs();
        chk("b_f4_blank", 32'(blank_out), 0);
        chk("b_f4_mode", 32'(mode_out), 9);
        chk("b_f4_pending", 32'(pending), 0);

        // Table-driven debounce / commit vectors.
        for (int i = 0; i < 7; i++) begin
            wait_phase(10);
            mon_ch   = 0;
            mon_pend = 1'b0;
            mon_en   = 1'b1;
            sw_in    = vecs[i].sw_a;
            repeat (vecs[i].hold) step();
            sw_in = vecs[i].sw_b;
            wait_fs();
            step();
            mon_en = 1'b0;
            chk($sformatf("vec%0d_pending_seen", i), 32'(mon_pend), 32'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_mode", i), 32'(mode_out), 32'(vecs[i].exp_mode));
            chk($sformatf("vec%0d_changes", i), mon_ch, vecs[i].exp_ch);
            repeat (3) wait_fs();
        end

        // Reverted switch near the frame counter wrap.
        wait_phase(5);
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        exp_fc = 16'hFFFE;
        step();
        chk("preload_fcnt", 32'(frame_cnt), 32'h0000FFFE);
        wait_phase(10);
        mon_ch = 0;
        mon_en = 1'b1;
        sw_in  = 4'h6;
        repeat (20) step();
        chk("revert_pending_up", 32'(pending), 1);
        sw_in = 4'h5;
        wait_phase(90);
        chk("revert_pending_down", 32'(pending), 0);
        wait_fs();
        step();
        mon_en = 1'b0;
        chk("revert_no_change", mon_ch, 0);
        chk("revert_mode", 32'(mode_out), 5);
        chk("fcnt_ffff", 32'(frame_cnt), 32'h0000FFFF);
        wait_fs();
        chk("fcnt_wrap", 32'(frame_cnt), 32'h00000000);
        chk("fcnt_model", 32'(frame_cnt), 32'(exp_fc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
